// File: rtl/fifo_rptr_empty.sv
// Read-side control of the dual-clock FIFO: 2-flop wptr synchroniser, binary/Gray read pointers, registered empty/almost-empty/level.
// Flags follow an accepted read one rclk later and a write-pointer change three rclk later; rinc while empty is dropped.
module fifo_rptr_empty #(
   parameter int ASIZE    = 4,
   parameter int AE_LEVEL = 2
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rinc,
   input  logic [ASIZE:0]   wptr,
   output logic [ASIZE-1:0] raddr,
   output logic [ASIZE:0]   rptr,
   output logic             rempty,
   output logic             raempty,
   output logic [ASIZE:0]   rlevel
);

   localparam logic [ASIZE:0] AE_THR = (ASIZE+1)'(AE_LEVEL);

   logic [ASIZE:0] rq1_wptr;
   logic [ASIZE:0] rq2_wptr;
   logic [ASIZE:0] rbin;
   logic [ASIZE:0] rbinnext;
   logic [ASIZE:0] rgraynext;
   logic [ASIZE:0] wbin_s;
   logic [ASIZE:0] rlevelnext;
   logic           rd_ok;

   assign rd_ok     = rinc & ~rempty;
   assign rbinnext  = rbin + {{ASIZE{1'b0}}, rd_ok};
   assign rgraynext = (rbinnext >> 1) ^ rbinnext;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= ASIZE; i++) begin : g_g2b
      assign wbin_s[i] = ^rq2_wptr[ASIZE:i];
   end

   // Modulo-2^(ASIZE+1) difference; the extra MSB separates a full FIFO from an empty one.
   assign rlevelnext = wbin_s - rbinnext;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
         rbin     <= '0;
         rptr     <= '0;
         rempty   <= 1'b1;
         raempty  <= 1'b1;
         rlevel   <= '0;
      end else begin
         rq1_wptr <= wptr;
         rq2_wptr <= rq1_wptr;
         rbin     <= rbinnext;
         rptr     <= rgraynext;
         rempty   <= (rgraynext == rq2_wptr);
         raempty  <= (rlevelnext <= AE_THR);
         rlevel   <= rlevelnext;
      end
   end

   assign raddr = rbin[ASIZE-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomised and directed bench for fifo_rptr_empty against a count-based model of the read side.
module tb_fifo_rptr_empty;

   localparam int ASIZE = 4;
   localparam int AE    = 2;
   localparam int DEPTH = 16;
   localparam int PMOD  = 32;

   logic             rclk = 1'b0;
   logic             rrst_n = 1'b0;
   logic             rinc = 1'b0;
   logic [ASIZE:0]   wptr = '0;
   logic [ASIZE-1:0] raddr;
   logic [ASIZE:0]   rptr;
   logic             rempty;
   logic             raempty;
   logic [ASIZE:0]   rlevel;

   fifo_rptr_empty #(.ASIZE(ASIZE), .AE_LEVEL(AE)) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rinc    (rinc),
      .wptr    (wptr),
      .raddr   (raddr),
      .rptr    (rptr),
      .rempty  (rempty),
      .raempty (raempty),
      .rlevel  (rlevel)
   );

   always #5 rclk = ~rclk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: write position driven on wptr, read count accepted so far, and the
   // write positions still travelling through the two-cycle crossing delay.
   int wcnt = 0;
   int rd   = 0;
   int sync_q[$];
   int exp_level = 0;
   int exp_empty = 1;
   int exp_ae    = 1;

   function automatic logic [ASIZE:0] gray(input int b);
      int m;
      m = b % PMOD;
      return (ASIZE+1)'(m ^ (m >> 1));
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, required %0d", tag, act, exp);
      end
   endtask

   task automatic set_w(input int w);
      wcnt = w % PMOD;
      wptr = gray(wcnt);
   endtask

   task automatic model_reset();
      rd        = 0;
      sync_q    = '{0, 0};
      exp_level = 0;
      exp_empty = 1;
      exp_ae    = 1;
   endtask

   task automatic check_all(input string ph);
      check({ph, ".rempty"},  32'(rempty),  32'(exp_empty));
      check({ph, ".raempty"}, 32'(raempty), 32'(exp_ae));
      check({ph, ".rlevel"},  32'(rlevel),  32'(exp_level));
      check({ph, ".raddr"},   32'(raddr),   32'(rd % DEPTH));
      check({ph, ".rptr"},    32'(rptr),    32'(gray(rd)));
   endtask

   // One rclk: update the model from the sampled inputs, then compare just after the edge.
   task automatic tick();
      int vis;
      @(posedge rclk);
      if (!rrst_n) begin
         model_reset();
      end else begin
         vis = sync_q[0];
         if (rinc && exp_empty == 0) rd = (rd + 1) % PMOD;
         exp_level = (vis + PMOD - rd) % PMOD;
         exp_empty = (exp_level == 0) ? 1 : 0;
         exp_ae    = (exp_level <= AE) ? 1 : 0;
         sync_q.delete(0);
         sync_q.push_back(wcnt);
      end
      #1;
      check_all("cyc");
   endtask

   task automatic apply_reset(input int w);
      rrst_n = 1'b0;
      rinc   = 1'b0;
      set_w(w);
      tick();
      tick();
      rrst_n = 1'b1;
   endtask

   initial begin
      int occ;
      int rd_pct;
      int wr_pct;
      model_reset();

      // Reset release, idle for 10 cycles.
      apply_reset(0);
      repeat (10) tick();
      check("idle.rempty", 32'(rempty), 1);
      check("idle.raempty", 32'(raempty), 1);
      check("idle.rlevel", 32'(rlevel), 0);
      check("idle.rptr", 32'(rptr), 0);

      // One write becomes visible on the third edge; one read empties again.
      set_w(1);
      tick();
      tick();
      check("sync2.rempty", 32'(rempty), 1);
      tick();
      check("sync3.rempty", 32'(rempty), 0);
      check("sync3.rlevel", 32'(rlevel), 1);
      check("sync3.raempty", 32'(raempty), 1);
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      check("rd1.raddr", 32'(raddr), 1);
      check("rd1.rptr", 32'(rptr), 1);
      check("rd1.rempty", 32'(rempty), 1);
      check("rd1.rlevel", 32'(rlevel), 0);

      // Full FIFO drained by a 17-cycle read burst.
      apply_reset(0);
      set_w(16);
      repeat (3) tick();
      check("full.rlevel", 32'(rlevel), 16);
      check("full.raempty", 32'(raempty), 0);
      rinc = 1'b1;
      repeat (17) tick();
      rinc = 1'b0;
      check("drain.rptr", 32'(rptr), 32'h18);
      check("drain.rempty", 32'(rempty), 1);

      // Bring rbin to 31, then read across the pointer wrap.
      set_w(31);
      repeat (3) tick();
      rinc = 1'b1;
      repeat (15) tick();
      rinc = 1'b0;
      check("pre_wrap.rptr", 32'(rptr), 32'h10);
      set_w(33);
      repeat (3) tick();
      check("wrap.rlevel", 32'(rlevel), 2);
      check("wrap.raddr0", 32'(raddr), 15);
      rinc = 1'b1;
      tick();
      check("wrap.raddr1", 32'(raddr), 0);
      check("wrap.rptr1", 32'(rptr), 0);
      tick();
      check("wrap.raddr2", 32'(raddr), 1);
      check("wrap.rptr2", 32'(rptr), 1);
      check("wrap.rempty", 32'(rempty), 1);

      // Reads held while empty are ignored.
      repeat (5) tick();
      rinc = 1'b0;
      check("empty_rd.rptr", 32'(rptr), 1);
      check("empty_rd.rlevel", 32'(rlevel), 0);

      // Random traffic with varying read and write densities.
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            rd_pct = $urandom_range(10, 95);
            wr_pct = $urandom_range(10, 95);
         end
         occ = (wcnt + PMOD - rd) % PMOD;
         if (occ < DEPTH && $urandom_range(0, 99) < wr_pct) begin
            if ($urandom_range(0, 7) == 0) set_w(wcnt + $urandom_range(1, DEPTH - occ));
            else set_w(wcnt + 1);
         end
         rinc = ($urandom_range(0, 99) < rd_pct);
         tick();
      end
      rinc = 1'b0;

      // Asynchronous reset in the middle of a read burst.
      apply_reset(0);
      set_w(8);
      repeat (3) tick();
      rinc = 1'b1;
      repeat (3) tick();
      #2;
      rrst_n = 1'b0;
      #1;
      check("arst.rempty", 32'(rempty), 1);
      check("arst.raempty", 32'(raempty), 1);
      check("arst.rlevel", 32'(rlevel), 0);
      check("arst.raddr", 32'(raddr), 0);
      check("arst.rptr", 32'(rptr), 0);
      tick();
      tick();
      rrst_n = 1'b1;
      rinc   = 1'b0;
      repeat (3) tick();
      check("recover.rlevel", 32'(rlevel), 8);
      check("recover.rempty", 32'(rempty), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
